// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES key-schedule definitions: key-length and FSM state enums,
// Nk/Nr lookup, rcon doubling (xtime) and the forward S-box.
// Optional feature macro: KEYEXP_AES256_EN. When defined, key_len 2
// (AES-256) is legal; otherwise only AES-128 and AES-192 are accepted.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_LEN_128 = 2'd0,
        KEY_LEN_192 = 2'd1,
        KEY_LEN_256 = 2'd2,
        KEY_LEN_BAD = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KEY_LEN_128: return NK_128;
            KEY_LEN_192: return NK_192;
            default:     return NK_256;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEY_LEN_128: return NR_128;
            KEY_LEN_192: return NR_192;
            default:     return NR_256;
        endcase
    endfunction

    function automatic logic key_len_legal(input logic [1:0] kl);
`ifdef KEYEXP_AES256_EN
        return kl != KEY_LEN_BAD;
`else
        return (kl == KEY_LEN_128) || (kl == KEY_LEN_192);
`endif
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 255 - int'(x);
        return SBOX_TABLE[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/keyexp_word_gen.sv
// ---------------------------------------------------------------------------
// keyexp_word_gen
// Combinational step of the key schedule for i >= Nk:
//   w[i] = w[i-Nk] ^ t(w[i-1], kmod, rcon)
// Ports: w_prev (32) w[i-1], w_nk (32) w[i-Nk], kmod (3) i mod Nk,
//        nk (4) words per key, rcon (8) round constant, w_out (32) w[i].
// Optional feature macro: KEYEXP_AES256_EN adds the kmod==4 SubWord path.
// ---------------------------------------------------------------------------
module keyexp_word_gen
    import aes_pkg::*;
(
    input  logic [31:0] w_prev,
    input  logic [31:0] w_nk,
    input  logic [2:0]  kmod,
    input  logic [3:0]  nk,
    input  logic [7:0]  rcon,
    output logic [31:0] w_out
);
    logic [31:0] rot_w;
    logic [31:0] sub_in;
    logic [31:0] sub_w;
    logic [31:0] t;

    rot_word u_rot (.w_in(w_prev), .w_out(rot_w));

    // One SubWord serves both the rotated (kmod==0) and plain (AES-256) paths.
    assign sub_in = (kmod == 3'd0) ? rot_w : w_prev;

    sub_word u_sub (.w_in(sub_in), .w_out(sub_w));

    always_comb begin
        t = w_prev;
        if (kmod == 3'd0) begin
            t = sub_w ^ {rcon, 24'h000000};
        end
`ifdef KEYEXP_AES256_EN
        else if ((nk == NK_256) && (kmod == 3'd4)) begin
            t = sub_w;
        end
`endif
    end

`ifndef KEYEXP_AES256_EN
    // Nk only selects the AES-256 path, which is absent in this build.
    logic unused_nk;
    assign unused_nk = ^nk;
`endif

    assign w_out = w_nk ^ t;
endmodule

// File: rtl/rot_word.sv
// ---------------------------------------------------------------------------
// rot_word
// Cyclic left rotation of a key-schedule word by one byte.
// Ports: w_in (32) word in, w_out (32) rotated word.
// ---------------------------------------------------------------------------
module rot_word (
    input  logic [31:0] w_in,
    output logic [31:0] w_out
);
    assign w_out = {w_in[23:0], w_in[31:24]};
endmodule

// File: rtl/sub_word.sv
// ---------------------------------------------------------------------------
// sub_word
// Applies the AES S-box to each byte of a word.
// Ports: w_in (32) word in, w_out (32) substituted word.
// ---------------------------------------------------------------------------
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] w_in,
    output logic [31:0] w_out
);
    assign w_out = {sbox(w_in[31:24]), sbox(w_in[23:16]),
                    sbox(w_in[15:8]),  sbox(w_in[7:0])};
endmodule

// File: rtl/key_expansion_multi.sv
// ---------------------------------------------------------------------------
// key_expansion_multi
// Iterative AES key schedule for AES-128/192/256. Generates one 32-bit
// word per cycle and emits every 4 words as a 128-bit round key.
// Optional feature macro: KEYEXP_AES256_EN (AES-256 support, 8-deep window).
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   start_in            request a run (sampled in IDLE only)
//   key_len_in (2)      0=128, 1=192, 2=256, 3=illegal
//   key_in (KEY_W)      cipher key, word 0 in the MSBs
//   ready_out           high in IDLE
//   busy_out            high in GEN or DRAIN
//   rk_out (128)        round key, word 4j in [127:96]
//   rk_valid_out        rk_out holds valid data
//   rk_ready_in         consumer accepts rk_out
//   rk_idx_out (IDX_W)  round index of rk_out
//   rk_last_out         rk_idx_out == Nr
//   err_out             one-cycle pulse on a rejected illegal start
//
// Round-key stream: a transfer happens on an edge where rk_valid_out and
// rk_ready_in are both high; rk_out/rk_idx_out/rk_last_out hold while
// rk_valid_out=1 and rk_ready_in=0, and a new key may load on the same
// edge the previous one is accepted.
// ---------------------------------------------------------------------------
module key_expansion_multi
    import aes_pkg::*;
#(
    parameter int KEY_W = 256,
    parameter int IDX_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_in,
    input  logic [1:0]       key_len_in,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic [127:0]     rk_out,
    output logic             rk_valid_out,
    input  logic             rk_ready_in,
    output logic [IDX_W-1:0] rk_idx_out,
    output logic             rk_last_out,
    output logic             err_out
);

`ifdef KEYEXP_AES256_EN
    localparam int WIN_D = 8;
`else
    localparam int WIN_D = 6;
`endif

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_sh;
    logic [3:0]       nk_q;
    logic [3:0]       nr_q;
    logic [5:0]       i_q;
    logic [2:0]       kmod_q;
    logic [7:0]       rcon_q;
    logic [31:0]      win [WIN_D];   // win[0] = w[i-1] ... win[WIN_D-1] = w[i-WIN_D]

    logic             start_ok;
    logic             grp_end;
    logic             stall;
    logic             word_fire;
    logic             last_word;
    logic             key_phase;
    logic             out_xfer;
    logic [31:0]      w_nk;
    logic [31:0]      gen_w;
    logic [31:0]      w_new;

    assign start_ok  = (state_q == IDLE) && start_in && key_len_legal(key_len_in);
    assign grp_end   = (i_q[1:0] == 2'b11);
    assign out_xfer  = rk_valid_out && rk_ready_in;
    // Only the 4th word of a group needs the output register, so only it stalls.
    assign stall     = grp_end && rk_valid_out && !rk_ready_in;
    assign word_fire = (state_q == GEN) && !stall;
    assign last_word = (i_q == {nr_q, 2'b11});
    assign key_phase = (i_q < {2'b00, nk_q});

    always_comb begin
        case (nk_q)
            NK_128:  w_nk = win[3];
`ifdef KEYEXP_AES256_EN
            NK_256:  w_nk = win[7];
`endif
            default: w_nk = win[5];
        endcase
    end

    keyexp_word_gen u_word_gen (
        .w_prev (win[0]),
        .w_nk   (w_nk),
        .kmod   (kmod_q),
        .nk     (nk_q),
        .rcon   (rcon_q),
        .w_out  (gen_w)
    );

    // Key words are consumed from the top of a shift register, so no
    // variable part-select is needed.
    assign w_new = key_phase ? key_sh[KEY_W-1 -: 32] : gen_w;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = GEN;
            GEN:     if (word_fire && last_word) state_d = DRAIN;
            DRAIN:   if (out_xfer && rk_last_out) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_out = (state_q == IDLE);
        busy_out  = (state_q == GEN) || (state_q == DRAIN);
    end

    // Datapath: key latch, counters, word window and output register.
    // The newest three window entries double as the group accumulator:
    // on the 4th word they hold words 4j..4j+2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_sh       <= '0;
            nk_q         <= '0;
            nr_q         <= '0;
            i_q          <= '0;
            kmod_q       <= '0;
            rcon_q       <= 8'h01;
            for (int k = 0; k < WIN_D; k++) win[k] <= '0;
            rk_out       <= '0;
            rk_valid_out <= 1'b0;
            rk_idx_out   <= '0;
            rk_last_out  <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            err_out <= (state_q == IDLE) && start_in && !key_len_legal(key_len_in);

            if (start_ok) begin
                key_sh <= key_in;
                nk_q   <= nk_of(key_len_in);
                nr_q   <= nr_of(key_len_in);
                i_q    <= '0;
                kmod_q <= '0;
                rcon_q <= 8'h01;
                for (int k = 0; k < WIN_D; k++) win[k] <= '0;
            end

            if (word_fire) begin
                if (key_phase) key_sh <= key_sh << 32;
                win[0] <= w_new;
                for (int k = 1; k < WIN_D; k++) win[k] <= win[k-1];
                i_q    <= i_q + 6'd1;
                kmod_q <= ({1'b0, kmod_q} == nk_q - 4'd1) ? 3'd0 : kmod_q + 3'd1;
                if (!key_phase && (kmod_q == 3'd0)) rcon_q <= xtime(rcon_q);
            end

            if (word_fire && grp_end) begin
                rk_out       <= {win[2], win[1], win[0], w_new};
                rk_valid_out <= 1'b1;
                rk_idx_out   <= IDX_W'(i_q[5:2]);
                rk_last_out  <= (i_q[5:2] == nr_q);
            end else if (out_xfer) begin
                rk_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_expansion_multi.sv
// ---------------------------------------------------------------------------
// tb_key_expansion_multi
// Scoreboard bench: each accepted start pushes the full expected round-key
// sequence (computed from the FIPS-197 rules with an arithmetic S-box) into
// exp_q; a negedge monitor pops and compares on every rk transfer and checks
// that stalled outputs hold.
// ---------------------------------------------------------------------------
module tb_key_expansion_multi;
    localparam int KEY_W = 256;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             RST = 1'b1;
    logic             start_in = 1'b0;
    logic [1:0]       key_len_in = 2'd0;
    logic [KEY_W-1:0] key_in = '0;
    logic             rk_ready_in = 1'b1;
    logic             ready_out, busy_out, rk_valid_out, rk_last_out, err_out;
    logic [127:0]     rk_out;
    logic [IDX_W-1:0] rk_idx_out;

    key_expansion_multi #(.KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .CLK(clk), .RST(RST), .start_in(start_in), .key_len_in(key_len_in),
        .key_in(key_in), .ready_out(ready_out), .busy_out(busy_out),
        .rk_out(rk_out), .rk_valid_out(rk_valid_out), .rk_ready_in(rk_ready_in),
        .rk_idx_out(rk_idx_out), .rk_last_out(rk_last_out), .err_out(err_out)
    );

    int           n_pass = 0;
    int           n_total = 0;
    logic [132:0] exp_q[$];
    logic [7:0]   sb [256];
    int           ready_pct = 100;
    logic [127:0] last_rk = '0;
    logic         held_v = 1'b0;
    logic [132:0] held = '0;

    localparam logic [255:0] K1 = 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_00000000_00000000_00000000_00000000;
    localparam logic [255:0] K2 = 256'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b_00000000_00000000;
    localparam logic [255:0] K3 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] m_sub(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic void model_push(input logic [1:0] len, input logic [255:0] key);
        int          nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = m_sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = m_sub(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++)
            exp_q.push_back({(j == nr), 4'(j), w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]});
    endfunction

    function automatic logic len_legal(input logic [1:0] len);
`ifdef KEYEXP_AES256_EN
        return len != 2'd3;
`else
        return len < 2'd2;
`endif
    endfunction

    // ---------------- consumer ready driver ----------------
    always @(posedge clk) begin
        #1;
        rk_ready_in = ($urandom_range(0, 99) < ready_pct);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!RST && rk_valid_out === 1'b1) begin
            if (held_v)
                chk("rk_stable_while_stalled", {rk_last_out, rk_idx_out, rk_out}, held);
            if (rk_ready_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rk_transfer", {rk_last_out, rk_idx_out, rk_out}, '0);
                end else begin
                    logic [132:0] e;
                    e = exp_q.pop_front();
                    chk("rk_transfer", {rk_last_out, rk_idx_out, rk_out}, e);
                    if (rk_last_out) last_rk = rk_out;
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held = {rk_last_out, rk_idx_out, rk_out};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic start_run(input logic [1:0] len, input logic [255:0] key);
        start_in = 1'b1;
        key_len_in = len;
        key_in = key;
        last_rk = '0;
        if (len_legal(len)) model_push(len, key);
        @(posedge clk);  // E0
        #1;
        start_in = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_cyc, input int mid_start);
        int cyc;
        cyc = 0;
        chk({name, "_busy_after_start"}, busy_out, 1'b1);
        while (ready_out !== 1'b1 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mid_start > 0) begin
                start_in = (cyc == mid_start);
                key_len_in = 2'd1;
                key_in = {8{$urandom()}};
            end
        end
        if (cyc >= 4000) chk({name, "_timeout"}, 1'b0, 1'b1);
        if (exp_cyc > 0) chk({name, "_run_length"}, cyc, exp_cyc);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_valid_low_at_end"}, rk_valid_out, 1'b0);
    endtask

    task automatic illegal_start(input logic [1:0] len);
        start_in = 1'b1;
        key_len_in = len;
        key_in = {8{$urandom()}};
        @(posedge clk);
        #1;
        start_in = 1'b0;
        chk("err_pulse_high", err_out, 1'b1);
        chk("err_stays_idle", {ready_out, busy_out}, 2'b10);
        @(posedge clk);
        #1;
        chk("err_pulse_one_cycle", err_out, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("err_no_keys", rk_valid_out, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, ready_out, 1'b1);
        chk({name, "_busy"}, busy_out, 1'b0);
        chk({name, "_valid"}, rk_valid_out, 1'b0);
        chk({name, "_rk"}, rk_out, '0);
        chk({name, "_idx"}, rk_idx_out, '0);
        chk({name, "_last"}, rk_last_out, 1'b0);
        chk({name, "_err"}, err_out, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        RST = 1'b0;

        // AES-128 known vector, full throughput
        start_run(2'd0, K1);
        wait_idle("aes128", 45, 0);
        chk("aes128_rk10", last_rk, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

        // AES-192 known vector
        start_run(2'd1, K2);
        wait_idle("aes192", 53, 0);
        chk("aes192_rk12", last_rk, 128'he98ba06f_448c773c_8ecc7204_01002202);

`ifdef KEYEXP_AES256_EN
        start_run(2'd2, K3);
        wait_idle("aes256", 61, 0);
        chk("aes256_rk14", last_rk, 128'hfe4890d1_e6188d0b_046df344_706c631e);
`else
        illegal_start(2'd2);
`endif

        // Backpressure
        ready_pct = 30;
        start_run(2'd0, K1);
        wait_idle("aes128_bp", 0, 0);
        chk("aes128_bp_rk10", last_rk, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        ready_pct = 100;

        // Reset while rk5 is presented, then immediate restart with AES-192
        start_run(2'd0, K1);
        repeat (24) begin
            @(posedge clk);
            #1;
        end
        chk("rk5_present_before_reset", {rk_valid_out, rk_idx_out}, {1'b1, 4'd5});
        RST = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs("midrun_reset");
        exp_q.delete();
        RST = 1'b0;
        start_run(2'd1, K2);
        wait_idle("restart192", 53, 0);
        chk("restart192_rk12", last_rk, 128'he98ba06f_448c773c_8ecc7204_01002202);

        // Illegal length, then a start asserted mid-run
        illegal_start(2'd3);
        start_run(2'd0, K1);
        wait_idle("midstart", 45, 10);
        chk("midstart_rk10", last_rk, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
        chk("midstart_no_err", err_out, 1'b0);

        // Random keys, lengths and backpressure
        for (int r = 0; r < 6; r++) begin
            logic [1:0] len;
            len = 2'($urandom_range(0, 2));
            ready_pct = $urandom_range(20, 100);
            if (len_legal(len)) begin
                start_run(len, {8{$urandom()}});
                wait_idle("random_run", 0, 0);
            end else begin
                illegal_start(len);
            end
        end
        ready_pct = 100;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/key_expansion_multi.md
Name: key_expansion_multi

Overview:
Iterative AES key schedule for AES-128, AES-192 and AES-256, selected per run by key_len_in.
- Generates one 32-bit schedule word per cycle, in FIPS-197 order.
- Packs each 4 words into a 128-bit round key and emits it on a valid/ready stream to the cipher round engine.
- Successor to the fixed-length 128-bit key expander in the AES datapath: adds multiple key lengths, output backpressure and error reporting.

Parameters:
- KEY_W, 256, width of key_in. Must be 256 when KEYEXP_AES256_EN is defined, and at least 192 otherwise.
- IDX_W, 4, width of rk_idx_out.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- start_in  in  1  request a run; sampled only in IDLE.
- key_len_in  in  2  key length: 0 = 128 (Nk=4, Nr=10), 1 = 192 (Nk=6, Nr=12), 2 = 256 (Nk=8, Nr=14), 3 = illegal.
- key_in  in  KEY_W  cipher key. Word 0 is in the MSBs [KEY_W-1 -: 32]; shorter keys use the top Nk words only.
- ready_out  out  1  high in IDLE (a start is accepted).
- busy_out  out  1  high in GEN or DRAIN.
- rk_out  out  128  round key; schedule word 4j is in [127:96].
- rk_valid_out  out  1  rk_out holds valid data.
- rk_ready_in  in  1  consumer accepts rk_out.
- rk_idx_out  out  IDX_W  round index j of rk_out (0..Nr).
- rk_last_out  out  1  high when rk_idx_out == Nr.
- err_out  out  1  one-cycle pulse when a start with an illegal key length is rejected.

Behaviour:
Reset (RST=1 at an edge):
- State goes to IDLE.
- All outputs go to 0 except ready_out, which goes to 1.
- Internal word window, accumulator, counters cleared; rcon set to 0x01.
- Reset mid-run abandons the run with no further rk transfers; a start is accepted in the first cycle after RST deasserts.

State machine:
- IDLE -> GEN when start_in=1 and key_len_in is legal. On that edge (E0): latch the key and length, set i=0, kmod=0, rcon=0x01, clear the accumulator.
- Illegal key_len_in with start_in=1: err_out pulses for one cycle, state stays IDLE, nothing is latched.
- start_in in GEN or DRAIN is ignored.

GEN, one word per non-stalled cycle:
- i < Nk: w[i] = key word i.
- Otherwise w[i] = w[i-Nk] ^ t, where t depends on kmod:
  - kmod == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}; rcon then updates to xtime(rcon) (shift left, xor 0x1B if the MSB was set).
  - Nk == 8 and kmod == 4: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
- kmod = i mod Nk, kept as a wrapping counter; no divider.
- Each word is shifted into an 8-deep window (w[i-1]..w[i-8]) and into the 4-word accumulator.
- When the 4th word of group j is generated and the output register is free or being accepted in the same cycle, the group loads directly into rk_out with rk_idx_out=j. The same-cycle accept-and-load has no bubble.
- Stall: if the 4th word is due but rk_valid_out=1 and rk_ready_in=0, word generation holds; i, kmod and rcon do not change.
- GEN -> DRAIN when word 4*(Nr+1)-1 has been loaded into the output register.

DRAIN -> IDLE when the transfer with rk_last_out=1 completes (rk_valid_out & rk_ready_in). rk_valid_out then drops.

Output stream:
- A transfer occurs when rk_valid_out & rk_ready_in.
- rk_out, rk_idx_out and rk_last_out are stable while rk_valid_out=1 and rk_ready_in=0.

Latency, with rk_ready_in tied to 1:
- Round key j is valid in the cycle after edge E0+4(j+1).
- Total run length is 4(Nr+1)+1 cycles, so ready_out rises 45, 53 or 61 cycles after E0 for 128, 192 and 256.

Optional Feature:
KEYEXP_AES256_EN
- Defined: AES-256 supported. Window depth 8; the kmod==4 SubWord path is present; key_len_in=2 is legal.
- Undefined: window depth 6; the kmod==4 path is removed; key_len_in=2 is treated as illegal (err_out pulse, stay IDLE).

Decomposition:
Shared package aes_pkg:
- key-length enum;
- Nk and Nr lookup constants;
- state enum (IDLE, GEN, DRAIN);
- xtime function.

Sub-module keyexp_word_gen, combinational: takes w[i-1], w[i-Nk], kmod, Nk and rcon, returns w[i]. It instantiates the existing RotWord and SubWord blocks. The FSM, window and output stream stay in key_expansion_multi.

Test Plan:
1. AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready_in=1 -> 11 keys; rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last_out=1; ready_out high 45 cycles after E0.
2. AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> 13 keys; rk12 = e98ba06f 448c773c 8ecc7204 01002202.
3. AES-256 (macro defined), key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> 15 keys; rk14 = fe4890d1 e6188d0b 046df344 706c631e. Repeat with the macro undefined -> err_out pulse, no keys emitted.
4. Backpressure on vector 1: rk_ready_in random at 30% high -> identical key sequence, rk_out held stable while stalled, no lost or duplicated rk_idx_out.
5. RST pulsed during rk5 of vector 1, then an immediate restart with vector 2 -> all outputs 0 during reset; restart yields a correct 13-key sequence starting at rk_idx_out=0.
6. start_in with key_len_in=3, and start_in asserted mid-run -> err_out pulses exactly one cycle in the first case; the start is ignored in the second with the run unaffected.
